// File: rtl/monster_pkg.sv
// Shared types and constants for the monster spawn scheduler.
package monster_pkg;

    localparam int NUM_ANGLES = 21;
    localparam int ANGLE_W    = 5;
    localparam int RADIUS_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        KILL,
        STEP,
        ALLOC
    } state_t;

    typedef struct packed {
        logic                alive;
        logic [ANGLE_W-1:0]  angle;
        logic [RADIUS_W-1:0] radius;
    } slot_t;

endpackage

// File: rtl/spawn_fifo.sv
// Small power-of-two FIFO that buffers spawn angles until a free slot is allocated.
module spawn_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/monster_spawn_scheduler.sv
// Live monster pool: spawn queue, slot allocation, radius stepping and kill handling.
// Build macro SPAWN_DEDUP_EN discards a queued spawn whose angle is already alive.
module monster_spawn_scheduler
    import monster_pkg::*;
#(
    parameter int NUM_SLOTS   = 8,
    parameter int MAX_RADIUS  = 15,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_spawn_valid,
    input  logic [ANGLE_W-1:0]            i_spawn_index,
    input  logic                          i_step_tick,
    input  logic                          i_kill_valid,
    input  logic [ANGLE_W-1:0]            i_kill_index,
    output logic                          o_kill_ready,
    output logic                          o_kill_ack,
    output logic                          o_kill_hit,
    output logic                          o_player_hit,
    output logic [NUM_SLOTS-1:0]          o_slot_alive,
    output logic [ANGLE_W*NUM_SLOTS-1:0]  o_slot_angle,
    output logic [RADIUS_W*NUM_SLOTS-1:0] o_slot_radius,
    output logic [7:0]                    o_drop_count
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    state_t              r_state, w_next;
    slot_t               r_slots [NUM_SLOTS];
    logic                r_kill_ready, r_step_pending;
    logic                r_kill_ack, r_kill_hit, r_player_hit;
    logic [ANGLE_W-1:0]  r_kill_index;
    logic [SLOT_W-1:0]   r_step_idx;
    logic [7:0]          r_drop_count;

    logic                w_full, w_empty, w_push, w_pop, w_in_range;
    logic                w_spawn_drop, w_dedup_drop;
    logic [ANGLE_W-1:0]  w_head;
    logic                w_free_found, w_kill_found, w_step_last;
    logic [SLOT_W-1:0]   w_free_idx, w_kill_idx;
    logic [RADIUS_W-1:0] w_kill_rad;
    slot_t               w_step_slot;
    logic [1:0]          w_drop_inc;
    logic [8:0]          w_drop_sum;

    assign w_in_range   = (i_spawn_index < ANGLE_W'(NUM_ANGLES));
    assign w_push       = i_spawn_valid && w_in_range && !w_full;
    assign w_spawn_drop = i_spawn_valid && !w_push;
    assign w_pop        = (r_state == ALLOC);

    spawn_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ANGLE_W)
    ) u_spawn_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (i_spawn_index),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Lowest free slot wins because the scan runs from the top index down.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slots[i].alive) begin
                w_free_found = 1'b1;
                w_free_idx   = SLOT_W'(i);
            end
        end
    end

    // Nearest matching monster; a strict compare keeps the lowest index on ties.
    always_comb begin
        w_kill_found = 1'b0;
        w_kill_idx   = '0;
        w_kill_rad   = '1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_slots[i].alive && (r_slots[i].angle == r_kill_index) &&
                (!w_kill_found || (r_slots[i].radius < w_kill_rad))) begin
                w_kill_found = 1'b1;
                w_kill_idx   = SLOT_W'(i);
                w_kill_rad   = r_slots[i].radius;
            end
        end
    end

`ifdef SPAWN_DEDUP_EN
    logic w_dup;
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_slots[i].alive && (r_slots[i].angle == w_head)) w_dup = 1'b1;
        end
    end
    assign w_dedup_drop = (r_state == ALLOC) && w_dup;
`else
    assign w_dedup_drop = 1'b0;
`endif

    assign w_step_slot = r_slots[r_step_idx];
    assign w_step_last = (r_step_idx == SLOT_W'(NUM_SLOTS - 1));
    assign w_drop_inc  = {1'b0, w_spawn_drop} + {1'b0, w_dedup_drop};
    assign w_drop_sum  = {1'b0, r_drop_count} + {7'd0, w_drop_inc};

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!r_kill_ready)                w_next = KILL;
                else if (r_step_pending)          w_next = STEP;
                else if (!w_empty && w_free_found) w_next = ALLOC;
            end
            KILL:    w_next = IDLE;
            STEP:    if (w_step_last) w_next = IDLE;
            ALLOC:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A tick seen while a step is pending or running folds into that step.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
            r_kill_ready   <= 1'b1;
            r_kill_index   <= '0;
            r_step_pending <= 1'b0;
            r_step_idx     <= '0;
            r_kill_ack     <= 1'b0;
            r_kill_hit     <= 1'b0;
            r_player_hit   <= 1'b0;
            r_drop_count   <= '0;
        end else begin
            r_kill_ack   <= 1'b0;
            r_kill_hit   <= 1'b0;
            r_player_hit <= 1'b0;
            r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            if (i_kill_valid && r_kill_ready) begin
                r_kill_index <= i_kill_index;
                r_kill_ready <= 1'b0;
            end
            if ((r_state == IDLE) && (w_next == STEP))    r_step_pending <= 1'b0;
            else if (i_step_tick && (r_state != STEP))   r_step_pending <= 1'b1;
            case (r_state)
                KILL: begin
                    r_kill_ready <= 1'b1;
                    r_kill_ack   <= 1'b1;
                    r_kill_hit   <= w_kill_found;
                    if (w_kill_found) r_slots[w_kill_idx] <= '0;
                end
                STEP: begin
                    r_step_idx <= w_step_last ? '0 : r_step_idx + 1'b1;
                    if (w_step_slot.alive) begin
                        if (w_step_slot.radius == '0) begin
                            r_slots[r_step_idx] <= '0;
                            r_player_hit        <= 1'b1;
                        end else begin
                            r_slots[r_step_idx].radius <= w_step_slot.radius - 1'b1;
                        end
                    end
                end
                ALLOC: begin
                    if (!w_dedup_drop) begin
                        r_slots[w_free_idx] <= '{alive: 1'b1, angle: w_head,
                                                 radius: RADIUS_W'(MAX_RADIUS)};
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
        assign o_slot_alive[g]                         = r_slots[g].alive;
        assign o_slot_angle[ANGLE_W*g +: ANGLE_W]      = r_slots[g].angle;
        assign o_slot_radius[RADIUS_W*g +: RADIUS_W]   = r_slots[g].radius;
    end

    assign o_kill_ready = r_kill_ready;
    assign o_kill_ack   = r_kill_ack;
    assign o_kill_hit   = r_kill_hit;
    assign o_player_hit = r_player_hit;
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_monster_spawn_scheduler.sv
// Self-checking bench for monster_spawn_scheduler using an operation-level pool model.
module tb_monster_spawn_scheduler;
    localparam int NS   = 8;
    localparam int MAXR = 15;
    localparam int QD   = 4;
    localparam int NA   = 21;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            i_spawn_valid = 1'b0, i_step_tick = 1'b0, i_kill_valid = 1'b0;
    logic [4:0]      i_spawn_index = '0, i_kill_index = '0;
    logic            o_kill_ready, o_kill_ack, o_kill_hit, o_player_hit;
    logic [NS-1:0]   o_slot_alive;
    logic [5*NS-1:0] o_slot_angle;
    logic [4*NS-1:0] o_slot_radius;
    logic [7:0]      o_drop_count;

    always #10 clk = ~clk;

    monster_spawn_scheduler dut (
        .clk(clk), .reset(reset),
        .i_spawn_valid(i_spawn_valid), .i_spawn_index(i_spawn_index),
        .i_step_tick(i_step_tick),
        .i_kill_valid(i_kill_valid), .i_kill_index(i_kill_index),
        .o_kill_ready(o_kill_ready), .o_kill_ack(o_kill_ack), .o_kill_hit(o_kill_hit),
        .o_player_hit(o_player_hit), .o_slot_alive(o_slot_alive),
        .o_slot_angle(o_slot_angle), .o_slot_radius(o_slot_radius),
        .o_drop_count(o_drop_count)
    );

    int checks = 0, errors = 0;
    int mon_phit = 0, mon_ack = 0, mon_hit = 0;
    int m_alive [NS], m_angle [NS], m_rad [NS];
    int m_q [$];
    int m_drop = 0, m_acks = 0, m_hits = 0, m_phits = 0;

    always @(negedge clk) begin
        if (o_player_hit === 1'b1) mon_phit++;
        if (o_kill_ack === 1'b1) begin
            mon_ack++;
            if (o_kill_hit === 1'b1) mon_hit++;
        end
    end

    // Reference model of the pool at the granularity of whole operations.
    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin m_alive[i] = 0; m_angle[i] = 0; m_rad[i] = 0; end
        m_q.delete();
        m_drop = 0;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < NS; i++) if (m_alive[i] == 0) return i;
        return -1;
    endfunction

    function automatic void model_drop();
        if (m_drop < 255) m_drop++;
    endfunction

    function automatic void model_alloc();
        while (m_q.size() > 0 && model_free() >= 0) begin
            int a;
            int f;
            bit dup;
            a = m_q.pop_front();
            dup = 1'b0;
`ifdef SPAWN_DEDUP_EN
            for (int i = 0; i < NS; i++) if (m_alive[i] != 0 && m_angle[i] == a) dup = 1'b1;
`endif
            if (dup) model_drop();
            else begin
                f = model_free();
                m_alive[f] = 1; m_angle[f] = a; m_rad[f] = MAXR;
            end
        end
    endfunction

    function automatic void model_spawn(input int idx);
        if (idx >= NA || m_q.size() >= QD) model_drop();
        else m_q.push_back(idx);
        model_alloc();
    endfunction

    function automatic void model_kill(input int idx);
        int best = -1;
        for (int i = 0; i < NS; i++)
            if (m_alive[i] != 0 && m_angle[i] == idx && (best < 0 || m_rad[i] < m_rad[best])) best = i;
        m_acks++;
        if (best >= 0) begin m_hits++; m_alive[best] = 0; m_angle[best] = 0; m_rad[best] = 0; end
        model_alloc();
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < NS; i++) begin
            if (m_alive[i] != 0) begin
                if (m_rad[i] == 0) begin m_alive[i] = 0; m_angle[i] = 0; m_phits++; end
                else m_rad[i] = m_rad[i] - 1;
            end
        end
        model_alloc();
    endfunction

    function automatic logic [NS-1:0] exp_alive();
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = (m_alive[i] != 0);
        return v;
    endfunction

    function automatic logic [5*NS-1:0] exp_angle(input bit mask_only);
        logic [5*NS-1:0] v = '0;
        for (int i = 0; i < NS; i++)
            if (m_alive[i] != 0) v[5*i +: 5] = mask_only ? 5'h1F : 5'(m_angle[i]);
        return v;
    endfunction

    function automatic logic [4*NS-1:0] exp_radius(input bit mask_only);
        logic [4*NS-1:0] v = '0;
        for (int i = 0; i < NS; i++)
            if (m_alive[i] != 0) v[4*i +: 4] = mask_only ? 4'hF : 4'(m_rad[i]);
        return v;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_spawn(input int idx);
        i_spawn_valid = 1'b1; i_spawn_index = 5'(idx);
        @(negedge clk);
        i_spawn_valid = 1'b0;
    endtask

    task automatic drive_kill(input int idx);
        i_kill_valid = 1'b1; i_kill_index = 5'(idx);
        @(negedge clk);
        i_kill_valid = 1'b0;
    endtask

    task automatic drive_tick();
        i_step_tick = 1'b1;
        @(negedge clk);
        i_step_tick = 1'b0;
    endtask

    task automatic do_spawn(input int idx); drive_spawn(idx); model_spawn(idx); settle(30); endtask
    task automatic do_kill(input int idx);  drive_kill(idx);  model_kill(idx);  settle(30); endtask
    task automatic do_tick(input int gap);  drive_tick();     model_tick();     settle(gap); endtask

    task automatic do_reset();
        reset = 1'b1;
        settle(2);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        settle(3);
        checks++; if (o_slot_alive !== '0) begin errors++; $display("[TB] FAIL reset_alive: got %0h expected 0", o_slot_alive); end
        checks++; if (o_slot_angle !== '0 || o_slot_radius !== '0) begin errors++; $display("[TB] FAIL reset_slots: angle %0h radius %0h expected 0", o_slot_angle, o_slot_radius); end
        checks++; if (o_kill_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", o_kill_ready); end
        checks++; if ({o_kill_ack, o_kill_hit, o_player_hit} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 000", {o_kill_ack, o_kill_hit, o_player_hit}); end
        checks++; if (o_drop_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", o_drop_count); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_spawn_latency();
        drive_spawn(7);
        model_spawn(7);
        @(negedge clk);
        checks++; if (o_slot_alive !== 8'h00) begin errors++; $display("[TB] FAIL spawn_early: got %0h expected 0", o_slot_alive); end
        @(negedge clk);
        checks++; if (o_slot_alive !== exp_alive()) begin errors++; $display("[TB] FAIL spawn_alive: got %0h expected %0h", o_slot_alive, exp_alive()); end
        checks++; if (o_slot_angle[4:0] !== 5'd7 || o_slot_radius[3:0] !== 4'd15) begin errors++; $display("[TB] FAIL spawn_slot0: angle %0d radius %0d expected 7/15", o_slot_angle[4:0], o_slot_radius[3:0]); end
        checks++; if (o_drop_count !== 8'd0) begin errors++; $display("[TB] FAIL spawn_drop: got %0d expected 0", o_drop_count); end
        settle(5);
    endtask

    task automatic test_step_to_centre();
        for (int k = 1; k <= 16; k++) begin
            do_tick(20);
            checks++; if (o_slot_alive[0] !== (m_alive[0] != 0)) begin errors++; $display("[TB] FAIL step_alive tick %0d: got %b expected %0d", k, o_slot_alive[0], m_alive[0]); end
            if (m_alive[0] != 0) begin
                checks++; if (o_slot_radius[3:0] !== 4'(m_rad[0])) begin errors++; $display("[TB] FAIL step_radius tick %0d: got %0d expected %0d", k, o_slot_radius[3:0], m_rad[0]); end
            end
            checks++; if (mon_phit !== m_phits) begin errors++; $display("[TB] FAIL step_player_hit tick %0d: got %0d expected %0d", k, mon_phit, m_phits); end
        end
    endtask

    task automatic test_kill_nearest();
        int kills [2] = '{3, 9};
        do_reset();
        do_spawn(8); do_spawn(3);
        for (int k = 0; k < 5; k++) do_tick(15);
        do_kill(8);
        do_spawn(3);
        for (int k = 0; k < 5; k++) do_tick(15);
        for (int n = 0; n < 2; n++) begin
            int hits_before = m_hits;
            drive_kill(kills[n]);
            model_kill(kills[n]);
            @(negedge clk);
            checks++; if (o_kill_ack !== 1'b0 || o_kill_ready !== 1'b0) begin errors++; $display("[TB] FAIL kill_early %0d: ack %b ready %b expected 0/0", kills[n], o_kill_ack, o_kill_ready); end
            @(negedge clk);
            checks++; if (o_kill_ack !== 1'b1 || o_kill_hit !== (m_hits != hits_before)) begin errors++; $display("[TB] FAIL kill_ack %0d: ack %b hit %b expected 1/%0d", kills[n], o_kill_ack, o_kill_hit, m_hits - hits_before); end
            settle(10);
            checks++; if (o_slot_alive !== exp_alive()) begin errors++; $display("[TB] FAIL kill_alive %0d: got %0h expected %0h", kills[n], o_slot_alive, exp_alive()); end
            checks++; if ((o_slot_radius & exp_radius(1)) !== exp_radius(0)) begin errors++; $display("[TB] FAIL kill_radius %0d: got %0h expected %0h", kills[n], o_slot_radius & exp_radius(1), exp_radius(0)); end
        end
    endtask

    task automatic test_pool_full();
        do_reset();
        for (int i = 0; i < NS; i++) do_spawn(i);
        for (int i = 0; i < 6; i++) begin
            i_spawn_valid = 1'b1; i_spawn_index = 5'(10 + i);
            @(negedge clk);
            model_spawn(10 + i);
        end
        i_spawn_valid = 1'b0;
        settle(10);
        checks++; if (o_drop_count !== 8'(m_drop)) begin errors++; $display("[TB] FAIL full_drop: got %0d expected %0d", o_drop_count, m_drop); end
        checks++; if (o_slot_alive !== exp_alive()) begin errors++; $display("[TB] FAIL full_alive: got %0h expected %0h", o_slot_alive, exp_alive()); end
        do_kill(0);
        checks++; if ((o_slot_angle & exp_angle(1)) !== exp_angle(0)) begin errors++; $display("[TB] FAIL full_refill: got %0h expected %0h", o_slot_angle & exp_angle(1), exp_angle(0)); end
        checks++; if (o_slot_alive !== exp_alive() || o_drop_count !== 8'(m_drop)) begin errors++; $display("[TB] FAIL full_after_kill: alive %0h drop %0d expected %0h/%0d", o_slot_alive, o_drop_count, exp_alive(), m_drop); end
    endtask

    task automatic test_bad_index();
        do_reset();
        do_spawn(25);
        checks++; if (o_drop_count !== 8'(m_drop) || o_slot_alive !== 8'h00) begin errors++; $display("[TB] FAIL bad_index: drop %0d alive %0h expected %0d/0", o_drop_count, o_slot_alive, m_drop); end
        do_spawn(4);
        do_spawn(4);
        checks++; if (o_slot_alive !== exp_alive()) begin errors++; $display("[TB] FAIL dup_alive: got %0h expected %0h", o_slot_alive, exp_alive()); end
        checks++; if (o_drop_count !== 8'(m_drop)) begin errors++; $display("[TB] FAIL dup_drop: got %0d expected %0d", o_drop_count, m_drop); end
    endtask

    task automatic test_simultaneous_reset();
        do_reset();
        do_spawn(5);
        i_spawn_valid = 1'b1; i_spawn_index = 5'd6;
        i_kill_valid  = 1'b1; i_kill_index  = 5'd5;
        i_step_tick   = 1'b1;
        @(negedge clk);
        i_spawn_valid = 1'b0; i_kill_valid = 1'b0; i_step_tick = 1'b0;
        m_acks++; m_hits++;
        settle(2);
        checks++; if (o_kill_ack !== 1'b1 || o_kill_hit !== 1'b1 || o_slot_alive !== 8'h00) begin errors++; $display("[TB] FAIL simul_kill_first: ack %b hit %b alive %0h expected 1/1/0", o_kill_ack, o_kill_hit, o_slot_alive); end
        settle(2);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (o_slot_alive !== '0 || o_slot_radius !== '0 || o_drop_count !== 8'd0) begin errors++; $display("[TB] FAIL midstep_reset_state: alive %0h radius %0h drop %0d expected 0", o_slot_alive, o_slot_radius, o_drop_count); end
        checks++; if ({o_kill_ready, o_kill_ack, o_kill_hit, o_player_hit} !== 4'b1000) begin errors++; $display("[TB] FAIL midstep_reset_flags: got %b expected 1000", {o_kill_ready, o_kill_ack, o_kill_hit, o_player_hit}); end
        reset = 1'b0;
        model_reset();
        settle(20);
        checks++; if (o_slot_alive !== '0 || mon_phit !== m_phits || mon_ack !== m_acks) begin errors++; $display("[TB] FAIL post_reset_quiet: alive %0h phit %0d ack %0d expected 0/%0d/%0d", o_slot_alive, mon_phit, mon_ack, m_phits, m_acks); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int op = $urandom_range(0, 9);
            if (op < 4) begin
                int idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 22);
                do_spawn(idx);
            end else if (op < 6) begin
                int live [$];
                int a;
                for (int i = 0; i < NS; i++) if (m_alive[i] != 0) live.push_back(m_angle[i]);
                if (live.size() > 0 && $urandom_range(0, 2) != 0) a = live[$urandom_range(0, live.size() - 1)];
                else a = $urandom_range(0, NA - 1);
                do_kill(a);
            end else begin
                do_tick(30);
            end
            checks++; if (o_slot_alive !== exp_alive()) begin errors++; $display("[TB] FAIL rand_alive op %0d: got %0h expected %0h", n, o_slot_alive, exp_alive()); end
            checks++; if ((o_slot_angle & exp_angle(1)) !== exp_angle(0)) begin errors++; $display("[TB] FAIL rand_angle op %0d: got %0h expected %0h", n, o_slot_angle & exp_angle(1), exp_angle(0)); end
            checks++; if ((o_slot_radius & exp_radius(1)) !== exp_radius(0)) begin errors++; $display("[TB] FAIL rand_radius op %0d: got %0h expected %0h", n, o_slot_radius & exp_radius(1), exp_radius(0)); end
            checks++; if (o_drop_count !== 8'(m_drop) || o_kill_ready !== 1'b1) begin errors++; $display("[TB] FAIL rand_drop op %0d: drop %0d ready %b expected %0d/1", n, o_drop_count, o_kill_ready, m_drop); end
            checks++; if (mon_phit !== m_phits || mon_ack !== m_acks || mon_hit !== m_hits) begin errors++; $display("[TB] FAIL rand_pulses op %0d: phit %0d ack %0d hit %0d expected %0d/%0d/%0d", n, mon_phit, mon_ack, mon_hit, m_phits, m_acks, m_hits); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_spawn_latency();
        test_step_to_centre();
        test_kill_nearest();
        test_pool_full();
        test_bad_index();
        test_simultaneous_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
